reg_file_2r1w: RTL and testbench

General-purpose register file for the lab CPU datapath: 2^ADDR_W words of WIDTH bits.
- One synchronous write port, driven by the writeback stage.
- Two combinational read ports, driven by decode.
- One debug read port, driven by the board display logic.
Address 0 is hardwired to zero. An optional write-to-read bypass makes a same-cycle writeback visible to decode.

---
 rtl/reg_file_2r1w_pkg.sv | 14 +
 rtl/reg_file_2r1w_if.sv | 32 +++
 rtl/reg_file_2r1w_rf_read_port.sv | 38 +++
 rtl/reg_file_2r1w.sv | 72 +++++++
 tb/tb_reg_file_2r1w.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/reg_file_2r1w_pkg.sv
// Shared constants for the lab CPU register file, also imported by the
// decode and writeback stages so they all agree on default sizes.
//   DEF_WIDTH  : default data word width
//   DEF_ADDR_W : default register address width
//   NUM_REGS   : register count at the default address width
//   REG_ZERO   : index of the hardwired-zero register
package reg_file_2r1w_pkg;

    localparam int DEF_WIDTH  = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int NUM_REGS   = 2 ** DEF_ADDR_W;
    localparam int REG_ZERO   = 0;

endpackage

// File: rtl/reg_file_2r1w_if.sv
// Register-file access bundle between the datapath stages and the file.
//   we, waddr, wdata    : writeback write port
//   raddr1/rdata1       : decode read port 1
//   raddr2/rdata2       : decode read port 2
//   dbg_addr/dbg_data   : board display read port
// master = datapath side, slave = register file side.
interface reg_file_2r1w_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5
);

    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [WIDTH-1:0]  wdata;
    logic [ADDR_W-1:0] raddr1;
    logic [WIDTH-1:0]  rdata1;
    logic [ADDR_W-1:0] raddr2;
    logic [WIDTH-1:0]  rdata2;
    logic [ADDR_W-1:0] dbg_addr;
    logic [WIDTH-1:0]  dbg_data;

    modport master (
        output we, waddr, wdata, raddr1, raddr2, dbg_addr,
        input  rdata1, rdata2, dbg_data
    );

    modport slave (
        input  we, waddr, wdata, raddr1, raddr2, dbg_addr,
        output rdata1, rdata2, dbg_data
    );

endinterface

// File: rtl/reg_file_2r1w_rf_read_port.sv
// One combinational read port of the register file.
//   raddr  : read address
//   stored : committed contents of register[raddr]
//   byp_en : a write is committing at the next edge (we, no reset, waddr!=0)
//   waddr  : write address being committed
//   wdata  : write data being committed
//   rdata  : read result
// Address zero always reads 0. With BYPASS set, an in-flight write to the
// same address is forwarded so decode sees it in the writeback cycle.
module rf_read_port
    import reg_file_2r1w_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int BYPASS = 1
) (
    input  logic [ADDR_W-1:0] raddr,
    input  logic [WIDTH-1:0]  stored,
    input  logic              byp_en,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    output logic [WIDTH-1:0]  rdata
);

    logic byp_hit;

    assign byp_hit = (BYPASS != 0) && byp_en && (raddr == waddr);

    always_comb begin
        rdata = stored;
        if (raddr == ADDR_W'(REG_ZERO)) begin
            rdata = '0;
        end else if (byp_hit) begin
            rdata = wdata;
        end
    end

endmodule

// File: rtl/reg_file_2r1w.sv
// General-purpose register file: 2^ADDR_W words of WIDTH bits, one
// synchronous write port, two decode read ports and one debug read port.
//   clk   : clock, all state updates on the rising edge
//   reset : synchronous, active-high; clears every register
//   bus   : slave side of reg_file_2r1w_if (write port + three read ports)
// Register 0 is hardwired to zero. The debug port never bypasses, so the
// display always shows committed state.
module reg_file_2r1w
    import reg_file_2r1w_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int BYPASS = 1
) (
    input  logic            clk,
    input  logic            reset,
    reg_file_2r1w_if.slave  bus
);

    localparam int NUM_WORDS = 2 ** ADDR_W;

    logic [WIDTH-1:0] regs_q [NUM_WORDS];
    logic [WIDTH-1:0] regs_d [NUM_WORDS];
    logic             wr_commit;

    // A write lands only if reset is low and it does not target register 0;
    // the same qualifier gates forwarding so reset never leaks write data.
    assign wr_commit = bus.we && !reset && (bus.waddr != ADDR_W'(REG_ZERO));

    always_comb begin
        regs_d = regs_q;
        if (reset) begin
            for (int i = 0; i < NUM_WORDS; i++) begin
                regs_d[i] = '0;
            end
        end else if (wr_commit) begin
            regs_d[bus.waddr] = bus.wdata;
        end
    end

    always_ff @(posedge clk) begin
        regs_q <= regs_d;
    end

    rf_read_port #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .BYPASS(BYPASS)) u_rd1 (
        .raddr  (bus.raddr1),
        .stored (regs_q[bus.raddr1]),
        .byp_en (wr_commit),
        .waddr  (bus.waddr),
        .wdata  (bus.wdata),
        .rdata  (bus.rdata1)
    );

    rf_read_port #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .BYPASS(BYPASS)) u_rd2 (
        .raddr  (bus.raddr2),
        .stored (regs_q[bus.raddr2]),
        .byp_en (wr_commit),
        .waddr  (bus.waddr),
        .wdata  (bus.wdata),
        .rdata  (bus.rdata2)
    );

    rf_read_port #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .BYPASS(0)) u_rd_dbg (
        .raddr  (bus.dbg_addr),
        .stored (regs_q[bus.dbg_addr]),
        .byp_en (wr_commit),
        .waddr  (bus.waddr),
        .wdata  (bus.wdata),
        .rdata  (bus.dbg_data)
    );

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Self-checking bench for reg_file_2r1w. Two instances (forwarding on and
// off) see identical stimulus and are compared against a plain array model
// of the register file.
module tb_reg_file_2r1w;

    localparam int W  = 32;
    localparam int AW = 5;
    localparam int N  = 2 ** AW;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    reg_file_2r1w_if #(.WIDTH(W), .ADDR_W(AW)) if_b ();
    reg_file_2r1w_if #(.WIDTH(W), .ADDR_W(AW)) if_n ();

    reg_file_2r1w #(.WIDTH(W), .ADDR_W(AW), .BYPASS(1)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (if_b.slave)
    );

    reg_file_2r1w #(.WIDTH(W), .ADDR_W(AW), .BYPASS(0)) dut_n (
        .clk   (clk),
        .reset (reset),
        .bus   (if_n.slave)
    );

    logic [W-1:0] mem [N];
    int vectors    = 0;
    int miscompares = 0;

    // Current stimulus, mirrored for the model
    logic          s_rst, s_we;
    logic [AW-1:0] s_wa, s_a1, s_a2, s_ad;
    logic [W-1:0]  s_wd;

    function automatic logic [W-1:0] model_rd(input logic [AW-1:0] a, input bit fwd);
        if (a == 0) return '0;
        if (fwd && s_we && !s_rst && s_wa != 0 && a == s_wa) return s_wd;
        return mem[a];
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic r, input logic we, input logic [AW-1:0] wa,
                         input logic [W-1:0] wd, input logic [AW-1:0] a1,
                         input logic [AW-1:0] a2, input logic [AW-1:0] ad);
        s_rst = r; s_we = we; s_wa = wa; s_wd = wd; s_a1 = a1; s_a2 = a2; s_ad = ad;
        reset = r;
        if_b.we = we; if_b.waddr = wa; if_b.wdata = wd;
        if_b.raddr1 = a1; if_b.raddr2 = a2; if_b.dbg_addr = ad;
        if_n.we = we; if_n.waddr = wa; if_n.wdata = wd;
        if_n.raddr1 = a1; if_n.raddr2 = a2; if_n.dbg_addr = ad;
    endtask

    // Commit the model state for the edge that is about to happen.
    task automatic edge_commit();
        @(posedge clk);
        if (s_rst) begin
            for (int i = 0; i < N; i++) mem[i] = '0;
        end else if (s_we && s_wa != 0) begin
            mem[s_wa] = s_wd;
        end
        #1;
    endtask

    // Drive one cycle of stimulus, check all outputs mid-cycle, then clock it.
    task automatic step(input logic r, input logic we, input logic [AW-1:0] wa,
                        input logic [W-1:0] wd, input logic [AW-1:0] a1,
                        input logic [AW-1:0] a2, input logic [AW-1:0] ad);
        drive(r, we, wa, wd, a1, a2, ad);
        #3;
        chk("byp_rdata1", if_b.rdata1,   model_rd(a1, 1'b1));
        chk("byp_rdata2", if_b.rdata2,   model_rd(a2, 1'b1));
        chk("byp_dbg",    if_b.dbg_data, model_rd(ad, 1'b0));
        chk("nob_rdata1", if_n.rdata1,   model_rd(a1, 1'b0));
        chk("nob_rdata2", if_n.rdata2,   model_rd(a2, 1'b0));
        chk("nob_dbg",    if_n.dbg_data, model_rd(ad, 1'b0));
        edge_commit();
    endtask

    initial begin
        logic [AW-1:0] ra, rb, rc, rw;

        for (int i = 0; i < N; i++) mem[i] = '0;

        // Storage is undefined until reset, so the first reset is unchecked.
        drive(1'b1, 1'b1, 5'd4, 32'hBAD0_BAD0, 5'd0, 5'd0, 5'd0);
        @(posedge clk); #1;
        edge_commit();

        // Everything reads zero after reset.
        for (int i = 0; i < N; i++) begin
            step(1'b0, 1'b0, 5'd0, 32'h0, AW'(i), AW'(N - 1 - i), AW'(i));
        end

        // Plain write then read back.
        step(1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF, 5'd1, 5'd2, 5'd3);
        step(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd6, 5'd5);
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd0, 5'd5);
        #3;
        chk("wr5_rdata1_lit", if_b.rdata1,   32'hDEAD_BEEF);
        chk("wr5_dbg_lit",    if_b.dbg_data, 32'hDEAD_BEEF);
        edge_commit();

        // Writes to register 0 are dropped and never forwarded.
        step(1'b0, 1'b1, 5'd0, 32'h1234_5678, 5'd0, 5'd0, 5'd0);
        step(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);

        // Forwarding versus committed state on the same register.
        step(1'b0, 1'b1, 5'd7, 32'h11, 5'd0, 5'd0, 5'd0);
        drive(1'b0, 1'b1, 5'd7, 32'h22, 5'd7, 5'd7, 5'd7);
        #3;
        chk("byp7_rdata1_lit", if_b.rdata1,   32'h22);
        chk("byp7_rdata2_lit", if_b.rdata2,   32'h22);
        chk("byp7_dbg_lit",    if_b.dbg_data, 32'h11);
        chk("nob7_rdata1_lit", if_n.rdata1,   32'h11);
        edge_commit();
        step(1'b0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd7, 5'd7);

        // Reset wins over a same-cycle write, and suppresses forwarding.
        step(1'b0, 1'b1, 5'd3, 32'h55, 5'd0, 5'd0, 5'd0);
        drive(1'b1, 1'b1, 5'd3, 32'hAA, 5'd3, 5'd3, 5'd3);
        #3;
        chk("rst_cycle_rdata1_lit", if_b.rdata1, 32'h55);
        edge_commit();
        step(1'b0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd3, 5'd3);

        // we=0 leaves the register alone and nothing is forwarded.
        step(1'b0, 1'b1, 5'd9, 32'h44, 5'd0, 5'd0, 5'd0);
        step(1'b0, 1'b0, 5'd9, 32'hFF, 5'd9, 5'd9, 5'd9);
        step(1'b0, 1'b0, 5'd0, 32'h0, 5'd9, 5'd9, 5'd9);

        // Randomised traffic, biased so read addresses often hit the write.
        for (int k = 0; k < 400; k++) begin
            rw = AW'($urandom_range(0, N - 1));
            ra = ($urandom_range(0, 2) == 0) ? rw : AW'($urandom_range(0, N - 1));
            rb = ($urandom_range(0, 2) == 0) ? rw : AW'($urandom_range(0, N - 1));
            rc = ($urandom_range(0, 2) == 0) ? rw : AW'($urandom_range(0, N - 1));
            step(($urandom_range(0, 39) == 0), ($urandom_range(0, 1) == 1), rw,
                 $urandom(), ra, rb, rc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
